// File: rtl/register_mod_nbits_if.sv
// -----------------------------------------------------------------------------
// register_mod_nbits_if
//   Bundles the synchronous control, data and status signals of one
//   register_mod_nbits stage. Clock and Clear_n are not in the bundle; they
//   stay plain ports on the register.
//
//   Control (driven by master): Enable, Sclr, Load, Inc, Dec, D[WIDTH-1:0]
//   Status  (driven by slave) : Q[WIDTH-1:0], Q_n[WIDTH-1:0],
//                               Carry, Borrow, Load_err
//
//   master : the block that issues requests, for example a controller or an
//            upstream stage.
//   slave  : the register itself.
// -----------------------------------------------------------------------------
interface register_mod_nbits_if #(
  parameter int WIDTH = 13
);
  logic             Enable;
  logic             Sclr;
  logic             Load;
  logic             Inc;
  logic             Dec;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_n;
  logic             Carry;
  logic             Borrow;
  logic             Load_err;

  modport master (
    output Enable, Sclr, Load, Inc, Dec, D,
    input  Q, Q_n, Carry, Borrow, Load_err
  );

  modport slave (
    input  Enable, Sclr, Load, Inc, Dec, D,
    output Q, Q_n, Carry, Borrow, Load_err
  );
endinterface

// File: rtl/register_mod_nbits.sv
// -----------------------------------------------------------------------------
// register_mod_nbits
//   Register of WIDTH bits that counts modulo MODULUS. It supports a
//   synchronous clear, a range-checked parallel load, and increment or
//   decrement with wrap. Registered Carry and Borrow pulses let several
//   instances be chained into a cascade.
//
//   Parameters: WIDTH (1..16), MODULUS (2..2^WIDTH), RESET_VAL (< MODULUS)
//   Ports:
//     Clock    rising-edge clock
//     Clear_n  asynchronous active-low reset; forces Q to RESET_VAL and
//              clears all pulses
//     bus      register_mod_nbits_if.slave
//                Enable, Sclr, Load, Inc, Dec, D  -> requests
//                Q, Q_n, Carry, Borrow, Load_err  <- state and pulses
//
//   Request priority when Enable=1:
//     Sclr > Load > Inc only > Dec only > (Inc and Dec together = no-op)
// -----------------------------------------------------------------------------
module register_mod_nbits #(
  parameter int WIDTH     = 13,
  parameter int MODULUS   = 8192,
  parameter int RESET_VAL = 0
) (
  input logic                  Clock,
  input logic                  Clear_n,
  register_mod_nbits_if.slave  bus
);

  // Stop elaboration on an illegal configuration.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("register_mod_nbits: WIDTH=%0d outside 1..16", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("register_mod_nbits: MODULUS=%0d outside 2..2^WIDTH", MODULUS);
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("register_mod_nbits: RESET_VAL=%0d not below MODULUS", RESET_VAL);
  end
  if ($bits(bus.D) != WIDTH) begin : g_bad_bus
    $error("register_mod_nbits: interface width differs from WIDTH");
  end

  // The limit is held in WIDTH+1 bits so that MODULUS = 2^WIDTH is still
  // representable and the range check on D cannot overflow.
  localparam logic [WIDTH:0]   LIMIT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             carry;
  logic             carry_next;
  logic             borrow;
  logic             borrow_next;
  logic             load_err;
  logic             load_err_next;

  always_comb begin
    // NOTE: every output of this block gets a default first. Without these
    // defaults, a path that does not assign a signal would infer a latch.
    q_next        = q;
    carry_next    = 1'b0;
    borrow_next   = 1'b0;
    load_err_next = 1'b0;

    if (bus.Enable) begin
      if (bus.Sclr) begin
        q_next = RST_Q;
      end else if (bus.Load) begin
        if ({1'b0, bus.D} < LIMIT) begin
          q_next = bus.D;
        end else begin
          load_err_next = 1'b1;   // out-of-range data is rejected; Q holds
        end
      end else if (bus.Inc && !bus.Dec) begin
        if (q == LAST_Q) begin
          q_next     = '0;
          carry_next = 1'b1;
        end else begin
          q_next = q + WIDTH'(1);
        end
      end else if (bus.Dec && !bus.Inc) begin
        if (q == '0) begin
          q_next      = LAST_Q;
          borrow_next = 1'b1;
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
      // Inc and Dec together, or no request at all: Q holds.
    end
  end

  // Release of Clear_n is not synchronised here. The integrator must supply
  // a clean deassertion.
  always_ff @(posedge Clock or negedge Clear_n) begin
    // NOTE: state is updated with non-blocking assignments, so every flop
    // samples values from before the edge. Blocking assignments here would
    // create order-dependent races between flops.
    if (!Clear_n) begin
      q        <= RST_Q;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q_next;
      carry    <= carry_next;
      borrow   <= borrow_next;
      load_err <= load_err_next;
    end
  end

  assign bus.Q        = q;
  assign bus.Q_n      = ~q;   // combinational, so it tracks Q through reset
  assign bus.Carry    = carry;
  assign bus.Borrow   = borrow;
  assign bus.Load_err = load_err;

endmodule

// File: tb/tb_register_mod_nbits.sv
// -----------------------------------------------------------------------------
// tb_register_mod_nbits
//   Drives three register instances:
//     id 0  reg13  : default parameters (13 bits, modulus 8192)
//     id 1  sec    : WIDTH=6, MODULUS=60
//     id 2  min    : WIDTH=6, MODULUS=60; its Inc is driven by sec.Carry and
//                    its Enable is shared with sec
//   Each clock step, a behavioural model predicts the next state of every
//   stage and pushes that prediction onto a scoreboard queue. One time unit
//   after the rising edge, the queue is drained and each entry is compared
//   with the stage outputs.
// -----------------------------------------------------------------------------
module tb_register_mod_nbits;

  logic Clock;
  logic Clear_n;

  register_mod_nbits_if #(.WIDTH(13)) reg_if ();
  register_mod_nbits_if #(.WIDTH(6))  sec_if ();
  register_mod_nbits_if #(.WIDTH(6))  min_if ();

  assign min_if.Inc    = sec_if.Carry;
  assign min_if.Enable = sec_if.Enable;

  register_mod_nbits dut_reg (
    .Clock   (Clock),
    .Clear_n (Clear_n),
    .bus     (reg_if)
  );

  register_mod_nbits #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) dut_sec (
    .Clock   (Clock),
    .Clear_n (Clear_n),
    .bus     (sec_if)
  );

  register_mod_nbits #(.WIDTH(6), .MODULUS(60), .RESET_VAL(0)) dut_min (
    .Clock   (Clock),
    .Clear_n (Clear_n),
    .bus     (min_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int id;
    int q;
    bit carry;
    bit borrow;
    bit load_err;
  } exp_t;

  exp_t sb[$];
  exp_t cur[3];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int mod_of(int id);
    return (id == 0) ? 8192 : 60;
  endfunction

  function automatic int mask_of(int id);
    return (id == 0) ? 32'h1FFF : 32'h3F;
  endfunction

  function automatic string name_of(int id);
    case (id)
      0:       return "reg13";
      1:       return "sec";
      default: return "min";
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Behavioural next-state prediction for one stage.
  function automatic exp_t model(int id, int q, bit en, bit sclr, bit load,
                                 bit inc, bit dec, int d);
    exp_t r;
    int   m;
    m          = mod_of(id);
    r.id       = id;
    r.q        = q;
    r.carry    = 1'b0;
    r.borrow   = 1'b0;
    r.load_err = 1'b0;
    if (en) begin
      if (sclr)                 r.q = 0;
      else if (load) begin
        if (d < m)              r.q = d;
        else                    r.load_err = 1'b1;
      end
      else if (inc && !dec) begin
        r.q = (q + 1) % m;
        r.carry = (q == m - 1);
      end
      else if (dec && !inc) begin
        r.q = (q == 0) ? m - 1 : q - 1;
        r.borrow = (q == 0);
      end
    end
    return r;
  endfunction

  task automatic compare(input exp_t e);
    logic [31:0] q, qn;
    logic        c, b, le;
    string       n;
    n = name_of(e.id);
    case (e.id)
      0: begin
        q = {19'b0, reg_if.Q}; qn = {19'b0, reg_if.Q_n};
        c = reg_if.Carry; b = reg_if.Borrow; le = reg_if.Load_err;
      end
      1: begin
        q = {26'b0, sec_if.Q}; qn = {26'b0, sec_if.Q_n};
        c = sec_if.Carry; b = sec_if.Borrow; le = sec_if.Load_err;
      end
      default: begin
        q = {26'b0, min_if.Q}; qn = {26'b0, min_if.Q_n};
        c = min_if.Carry; b = min_if.Borrow; le = min_if.Load_err;
      end
    endcase
    check({n, ".Q"},        q,  e.q);
    check({n, ".Q_n"},      qn, (~e.q) & mask_of(e.id));
    check({n, ".Carry"},    {31'b0, c},  {31'b0, e.carry});
    check({n, ".Borrow"},   {31'b0, b},  {31'b0, e.borrow});
    check({n, ".Load_err"}, {31'b0, le}, {31'b0, e.load_err});
  endtask

  // Clear_n is low: every stage must show the reset state now, with no edge.
  task automatic check_reset();
    for (int i = 0; i < 3; i++) begin
      cur[i] = '{id: i, q: 0, carry: 1'b0, borrow: 1'b0, load_err: 1'b0};
      compare(cur[i]);
    end
  endtask

  // One clock step. Predict the outcome from the inputs as they stand, push
  // the prediction, let the edge happen, then drain and compare. The step
  // returns on the falling edge, ready for the next drive.
  task automatic step();
    exp_t nxt[3];
    nxt[0] = model(0, cur[0].q, reg_if.Enable, reg_if.Sclr, reg_if.Load,
                   reg_if.Inc, reg_if.Dec, int'(reg_if.D));
    nxt[1] = model(1, cur[1].q, sec_if.Enable, sec_if.Sclr, sec_if.Load,
                   sec_if.Inc, sec_if.Dec, int'(sec_if.D));
    nxt[2] = model(2, cur[2].q, sec_if.Enable, min_if.Sclr, min_if.Load,
                   cur[1].carry, min_if.Dec, int'(min_if.D));
    for (int i = 0; i < 3; i++) begin
      cur[i] = nxt[i];
      sb.push_back(nxt[i]);
    end
    @(posedge Clock);
    #1;
    while (sb.size() > 0) compare(sb.pop_front());
    @(negedge Clock);
  endtask

  task automatic drive_reg(bit en, bit sclr, bit load, bit inc, bit dec, int d);
    reg_if.Enable = en; reg_if.Sclr = sclr; reg_if.Load = load;
    reg_if.Inc = inc;   reg_if.Dec = dec;   reg_if.D = 13'(d);
  endtask

  task automatic drive_sec(bit en, bit sclr, bit load, bit inc, bit dec, int d);
    sec_if.Enable = en; sec_if.Sclr = sclr; sec_if.Load = load;
    sec_if.Inc = inc;   sec_if.Dec = dec;   sec_if.D = 6'(d);
  endtask

  task automatic drive_min(bit sclr, bit load, int d);
    min_if.Sclr = sclr; min_if.Load = load; min_if.Dec = 1'b0; min_if.D = 6'(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Clear_n = 1'b0;
    drive_reg(1, 0, 0, 0, 0, 0);
    drive_sec(1, 0, 0, 0, 0, 0);
    drive_min(0, 0, 0);

    // Reset takes effect before any edge and holds across an edge.
    #2 check_reset();
    @(posedge Clock); #1 check_reset();
    @(negedge Clock); Clear_n = 1'b1;

    // Load 1234, then count, then assert Clear_n between edges.
    drive_reg(1, 0, 1, 0, 0, 1234); step();
    drive_reg(1, 0, 0, 1, 0, 0);    step();
    #2 Clear_n = 1'b0;
    #1 check_reset();
    @(negedge Clock); Clear_n = 1'b1;

    // 13-bit natural rollover: 8191 -> 0 raises Carry.
    drive_reg(1, 0, 1, 0, 0, 8190); step();
    drive_reg(1, 0, 0, 1, 0, 0);    repeat (3) step();
    drive_reg(1, 0, 0, 0, 0, 0);    step();

    // Count up through the wrap at 60: 59, 0 (Carry), 1.
    drive_sec(1, 0, 1, 0, 0, 58); step();
    drive_sec(1, 0, 0, 1, 0, 0);  repeat (3) step();

    // Count down through the wrap: 0, 59 (Borrow).
    drive_sec(1, 0, 1, 0, 0, 1);  step();
    drive_sec(1, 0, 0, 0, 1, 0);  repeat (2) step();

    // Priority, range check, Inc+Dec no-op, Load beats Inc.
    drive_sec(1, 0, 1, 0, 0, 10); step();
    drive_sec(1, 1, 1, 1, 0, 20); step();
    drive_sec(1, 0, 1, 0, 0, 10); step();
    drive_sec(1, 0, 1, 0, 0, 63); step();
    drive_sec(1, 0, 0, 1, 1, 0);  step();
    drive_sec(1, 0, 1, 1, 0, 30); step();
    drive_sec(1, 0, 0, 0, 0, 0);  step();

    // Enable gating at 59, then release the gate.
    drive_sec(1, 0, 1, 0, 0, 59); step();
    drive_sec(0, 0, 0, 1, 0, 0);  repeat (4) step();
    drive_sec(1, 0, 0, 1, 0, 0);  step();
    drive_sec(1, 0, 0, 0, 0, 0);  step();

    // Cascade: 59/59, one Inc on seconds; minutes ripples one cycle later.
    drive_sec(1, 0, 1, 0, 0, 59); drive_min(0, 1, 59); step();
    drive_min(0, 0, 0);
    drive_sec(1, 0, 0, 1, 0, 0);  step();
    drive_sec(1, 0, 0, 0, 0, 0);  repeat (2) step();
    drive_sec(1, 0, 0, 1, 0, 0);  repeat (3) step();

    // Assert Clear_n mid-count: both stages return to 0 with no edge.
    #2 Clear_n = 1'b0;
    #1 check_reset();
    @(negedge Clock); Clear_n = 1'b1;
    drive_sec(1, 0, 0, 0, 0, 0);  step();

    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
